// File: rtl/instruction_fetch_unit.sv
// RV32IM fetch stage: owns the PC, one outstanding imem request at a time.
// Presents {pc, inst, valid} to IF/ID; honours stall and EX redirect.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        drop_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_inst_q;
  logic        if_valid_q;

  logic [31:0] tgt_d;
  logic [31:0] pc_inc_d;
  logic        unused_bits;

  assign tgt_d       = {redirect_pc[31:2], 2'b00};
  assign pc_inc_d    = pc_q + 32'd4;
  assign unused_bits = ^redirect_pc[1:0];

  assign imem_req  = (state_q == REQ);
  assign imem_addr = pc_q;
  assign if_pc     = if_pc_q;
  assign if_inst   = if_inst_q;
  assign if_valid  = if_valid_q;

  // Fetch FSM: PC, drop flag and the registered IF/ID outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      if_pc_q    <= 32'd0;
      if_inst_q  <= NOP_INST;
      if_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (redirect_valid) pc_q <= tgt_d;
          state_q <= REQ;
        end
        REQ: begin
          if (redirect_valid) pc_q <= tgt_d;
          if (imem_gnt) begin
            // A redirect racing the grant leaves a stale response in flight.
            drop_q  <= redirect_valid;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (redirect_valid) pc_q <= tgt_d;
          if (imem_rvalid) begin
            if (drop_q || redirect_valid) begin
              drop_q  <= 1'b0;
              state_q <= REQ;
            end else begin
              if_inst_q  <= imem_rdata;
              if_pc_q    <= pc_q;
              if_valid_q <= 1'b1;
              state_q    <= HOLD;
            end
          end else if (redirect_valid) begin
            drop_q <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid || !stall) begin
            if_valid_q <= 1'b0;
            if_inst_q  <= NOP_INST;
            pc_q       <= redirect_valid ? tgt_d : pc_inc_d;
            state_q    <= REQ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit: memory model, stall/redirect
// driver and a scoreboard of the architectural fetch stream.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  instruction_fetch_unit #(
    .RESET_PC(RESET_PC),
    .NOP_INST(NOP_INST)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .if_valid      (if_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected PCs of the architectural fetch stream, oldest first.
  logic [31:0] q[$];

  int p_gnt = 100;
  int p_stall = 0;
  int p_redir = 0;
  int lat_min = 0;
  int lat_max = 0;
  logic        force_req = 1'b0;
  logic [31:0] force_tgt = 32'd0;

  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = 32'd0;
  logic        gr_s = 1'b0;
  logic        rv_s = 1'b0;
  logic [31:0] addr_s = 32'd0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'd0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: memory responder plus random stall/redirect; pushes expectations.
  initial begin
    logic [31:0] tgt;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    stall = 0; redirect_valid = 0; redirect_pc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 0; gr_s = 0; rv_s = 0;
        imem_gnt = 0; imem_rvalid = 0;
        redirect_valid = 0; stall = 0;
        q.delete();
        q.push_back(RESET_PC);
        continue;
      end
      if (rv_s) pend = 0;
      if (gr_s) begin
        pend = 1;
        cnt = $urandom_range(lat_max, lat_min);
        paddr = addr_s;
      end
      imem_rvalid = pend && (cnt == 0);
      imem_rdata = imem_rvalid ? memfn(paddr) : $urandom;
      if (pend && cnt > 0) cnt--;
      if (imem_req) chk("one_outstanding", {31'd0, pend}, 32'd0);
      imem_gnt = ($urandom_range(99) < p_gnt);
      stall = ($urandom_range(99) < p_stall);
      if ($urandom_range(3) == 0) tgt = $urandom;
      else tgt = $urandom & 32'h0000_03FF;
      if (force_req) begin
        redirect_valid = 1;
        tgt = force_tgt;
        force_req = 0;
      end else begin
        redirect_valid = ($urandom_range(99) < p_redir);
      end
      redirect_pc = tgt;
      if (redirect_valid) begin
        q.delete();
        q.push_back({tgt[31:2], 2'b00});
      end else if (if_valid && !stall) begin
        q.push_back(q[$] + 32'd4);
      end
      gr_s = imem_req && imem_gnt;
      rv_s = imem_rvalid;
      addr_s = imem_addr;
    end
  end

  // Monitor: pops the expected stream whenever IF/ID consumes an instruction.
  initial begin
    logic        prev_hold;
    logic        prev_req_wait;
    logic [31:0] h_pc, h_inst, h_addr;
    logic [31:0] e;
    prev_hold = 0;
    prev_req_wait = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_hold = 0;
        prev_req_wait = 0;
        continue;
      end
      if (!if_valid) chk("bubble_nop", if_inst, NOP_INST);
      if (prev_hold) begin
        chk("hold_valid", {31'd0, if_valid}, 32'd1);
        chk("hold_pc", if_pc, h_pc);
        chk("hold_inst", if_inst, h_inst);
        chk("hold_req", {31'd0, imem_req}, 32'd0);
      end
      if (prev_req_wait) begin
        chk("ungranted_req", {31'd0, imem_req}, 32'd1);
        chk("ungranted_addr", imem_addr, h_addr);
      end
      if (imem_req && !redirect_valid && q.size() > 0)
        chk("req_addr", imem_addr, q[0]);
      if (if_valid && !stall && !redirect_valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL consume_empty: got pc %h expected none", if_pc);
        end else begin
          e = q.pop_front();
          chk("consume_pc", if_pc, e);
          chk("consume_inst", if_inst, memfn(e));
        end
      end
      prev_hold = if_valid && stall && !redirect_valid;
      prev_req_wait = imem_req && !imem_gnt && !redirect_valid;
      h_pc = if_pc;
      h_inst = if_inst;
      h_addr = imem_addr;
    end
  end

  // Sequencer: directed scenarios around a long randomized run.
  initial begin
    bit found;
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_inst", if_inst, NOP_INST);
    chk("rst_pc", if_pc, 32'd0);
    @(posedge clk);
    #2 rst = 0;

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RESET_PC);
    @(negedge clk);
    #1;
    chk("wait_noreq", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    #1;
    chk("first_valid", {31'd0, if_valid}, 32'd1);
    chk("first_pc", if_pc, 32'd0);
    chk("first_inst", if_inst, 32'h0050_0093);
    @(negedge clk);
    #1;
    chk("second_addr", imem_addr, 32'h4);

    p_gnt = 70; p_stall = 30; p_redir = 5;
    lat_min = 0; lat_max = 2;
    repeat (4000) @(posedge clk);

    p_redir = 0;
    @(posedge clk);
    #2;
    force_tgt = 32'hFFFF_FFFE;
    force_req = 1;
    @(posedge clk);
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      #1;
      if (imem_req && imem_addr == 32'd0) found = 1;
    end
    chk("wrap_seen", {31'd0, found}, 32'd1);

    p_gnt = 100; p_stall = 0;
    lat_min = 3; lat_max = 3;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge clk);
      #2;
      if (pend) found = 1;
    end
    chk("pend_seen", {31'd0, found}, 32'd1);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_valid", {31'd0, if_valid}, 32'd0);
    chk("midrst_inst", if_inst, NOP_INST);
    @(posedge clk);
    #2 rst = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      #1;
      if (imem_req) found = 1;
    end
    chk("midrst_reqseen", {31'd0, found}, 32'd1);
    chk("midrst_addr", imem_addr, RESET_PC);
    repeat (20) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
